// File: rtl/gate_pkg.sv
// gate_pkg: op-select encodings and BIST FSM state type shared by the gate bank, its BIST and the bench
package gate_pkg;
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} bist_state_t;
endpackage

// File: rtl/gate_golden.sv
// gate_golden: combinational reference model of the gate bank
// ports: op (2b select), a, b (WIDTH operands), y (expected result; NOT ignores b)
module gate_golden import gate_pkg::*; #(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = op == OP_AND ? (a & b) :
        op == OP_OR  ? (a | b) :
        op == OP_XOR ? (a ^ b) : ~a;
  end
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer sweeping every op x operand vector through the gate bank
// ports: clk, rst_n (sync active-low), start, abort in; dut_a/dut_b/dut_op drive the bank,
//   dut_y is its result; busy/done/pass/err_count report status.
// GATE_BIST_FAILCAP_EN adds fail_valid/fail_op/fail_a/fail_b capturing the first mismatch.
module gate_bist_ctrl import gate_pkg::*; #(
  parameter int WIDTH     = 1,
  parameter int SETTLE    = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic [1:0]           dut_op,
  input  logic [WIDTH-1:0]     dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
`ifdef GATE_BIST_FAILCAP_EN
  output logic                 fail_valid,
  output logic [1:0]           fail_op,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
`endif
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int IW = 2 + 2 * WIDTH;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  bist_state_t          state;
  logic [IW-1:0]        idx;
  logic [SW-1:0]        cnt;
  logic [WIDTH-1:0]     gold_y;
  logic                 miss;
  logic [ERR_CNT_W-1:0] err_nx;
  gate_golden #(.WIDTH(WIDTH)) u_gold (.op(dut_op), .a(dut_a), .b(dut_b), .y(gold_y));
  // the bank sees registered operands, so gold_y and dut_y are both settled by CHECK
  always_comb begin
    miss   = dut_y != gold_y;
    err_nx = (miss && err_count != {ERR_CNT_W{1'b1}}) ? err_count + 1'b1 : err_count;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      dut_a     <= '0;
      dut_b     <= '0;
      dut_op    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
`ifdef GATE_BIST_FAILCAP_EN
      fail_valid <= 1'b0;
      fail_op    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
`endif
    end else if (abort && (state == APPLY || state == WAIT || state == CHECK)) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // abort outranks start, even where abort itself has no effect
          if (start && !abort) begin
            state     <= APPLY;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef GATE_BIST_FAILCAP_EN
            fail_valid <= 1'b0;
            fail_op    <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
`endif
          end
        end
        APPLY: begin
          dut_op <= idx[IW-1 -: 2];
          dut_a  <= idx[2*WIDTH-1 -: WIDTH];
          dut_b  <= idx[WIDTH-1:0];
          cnt    <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == SW'(SETTLE - 1)) state <= CHECK;
          else cnt <= cnt + 1'b1;
        end
        CHECK: begin
          err_count <= err_nx;
`ifdef GATE_BIST_FAILCAP_EN
          if (miss && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_op    <= dut_op;
            fail_a     <= dut_a;
            fail_b     <= dut_b;
          end
`endif
          if (idx == {IW{1'b1}}) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_nx == '0;
          end else begin
            idx   <= idx + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
